// File: rtl/cache_pkg.sv
// Shared cache defaults and the line-fill FSM state encoding.
package cache_pkg;

    localparam int unsigned DEFAULT_WORD_SIZE  = 32;
    localparam int unsigned DEFAULT_WORD_COUNT = 4;
    localparam int unsigned DEFAULT_ADDR_WIDTH = 15;
    localparam int unsigned FILL_COUNT_WIDTH   = 14;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2,
        StDone = 2'd3
    } fill_state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned WIDTH = 14
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/line_fill_unit.sv
// Fetches a full cache line word by word from main memory on a miss,
// always starting at the line-aligned base and walking up in order.
module line_fill_unit
    import cache_pkg::*;
#(
    parameter int unsigned WORD_SIZE  = DEFAULT_WORD_SIZE,
    parameter int unsigned WORD_COUNT = DEFAULT_WORD_COUNT,
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             fill_req,
    input  logic [ADDR_WIDTH-1:0]            fill_addr,
    output logic                             fill_busy,
    output logic                             fill_done,
    output logic [WORD_COUNT*WORD_SIZE-1:0]  line_data,
    output logic                             mem_rd,
    output logic [ADDR_WIDTH-1:0]            mem_addr,
    input  logic [WORD_SIZE-1:0]             mem_rdata,
    input  logic                             mem_rvalid,
    output logic [FILL_COUNT_WIDTH-1:0]      fill_count
);

    localparam int unsigned IDX_W  = $clog2(WORD_COUNT);
    localparam int unsigned BASE_W = ADDR_WIDTH - IDX_W;
    localparam int unsigned LINE_W = WORD_COUNT * WORD_SIZE;

    fill_state_e              state_q, state_d;
    logic [IDX_W-1:0]         index_q, index_d;
    logic [BASE_W-1:0]        base_q, base_d;
    logic [LINE_W-1:0]        line_q, line_d;

    always_comb begin
        state_d = state_q;
        index_d = index_q;
        base_d  = base_q;
        line_d  = line_q;

        unique case (state_q)
            StIdle: begin
                if (fill_req) begin
                    base_d  = fill_addr[ADDR_WIDTH-1:IDX_W];
                    index_d = '0;
                    state_d = StReq;
                end
            end
            StReq: begin
                state_d = StWait;
            end
            StWait: begin
                // No timeout: memory is trusted to answer eventually.
                if (mem_rvalid) begin
                    line_d[index_q*WORD_SIZE +: WORD_SIZE] = mem_rdata;
                    if (index_q == IDX_W'(WORD_COUNT - 1)) begin
                        state_d = StDone;
                    end else begin
                        index_d = index_q + IDX_W'(1);
                        state_d = StReq;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            index_q <= '0;
            base_q  <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            base_q  <= base_d;
            line_q  <= line_d;
        end
    end

    // Base has zero low bits, so concatenation equals base+index without overflow.
    assign fill_busy = (state_q != StIdle);
    assign fill_done = (state_q == StDone);
    assign mem_rd    = (state_q == StReq);
    assign mem_addr  = mem_rd ? {base_q, index_q} : '0;
    assign line_data = line_q;

    sat_counter #(
        .WIDTH(FILL_COUNT_WIDTH)
    ) u_fill_counter (
        .clk_i  (clk),
        .rst_i  (rst),
        .inc_i  (fill_done),
        .count_o(fill_count)
    );

endmodule

// File: tb/tb_line_fill_unit.sv
// Scoreboard bench for line_fill_unit with a variable-latency memory responder.
module tb_line_fill_unit;

    localparam int unsigned WS = 32;
    localparam int unsigned WC = 4;
    localparam int unsigned AW = 15;
    localparam int unsigned LW = WS * WC;

    logic          clk = 1'b0;
    logic          rst;
    logic          fill_req;
    logic [AW-1:0] fill_addr;
    logic          fill_busy;
    logic          fill_done;
    logic [LW-1:0] line_data;
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic [WS-1:0] mem_rdata;
    logic          mem_rvalid;
    logic [13:0]   fill_count;

    logic          sat_rst;
    logic          sat_inc;
    logic [13:0]   sat_count;

    always #5 clk = ~clk;

    line_fill_unit #(
        .WORD_SIZE (WS),
        .WORD_COUNT(WC),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .fill_req  (fill_req),
        .fill_addr (fill_addr),
        .fill_busy (fill_busy),
        .fill_done (fill_done),
        .line_data (line_data),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .mem_rvalid(mem_rvalid),
        .fill_count(fill_count)
    );

    sat_counter #(
        .WIDTH(14)
    ) u_sat (
        .clk_i  (clk),
        .rst_i  (sat_rst),
        .inc_i  (sat_inc),
        .count_o(sat_count)
    );

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned done_seen = 0;
    int unsigned lat = 1;
    int unsigned exp_count = 0;

    logic [AW-1:0] exp_addr_q[$];
    logic [LW-1:0] exp_line_q[$];

    logic          resp_valid = 1'b0;
    logic [WS-1:0] resp_data  = '0;
    logic          inj_valid  = 1'b0;
    logic [WS-1:0] inj_data   = '0;

    assign mem_rvalid = resp_valid | inj_valid;
    assign mem_rdata  = resp_valid ? resp_data : inj_data;

    function automatic logic [WS-1:0] mem_word(input logic [AW-1:0] a);
        return {a ^ 15'h5A5A, 2'b10, a};
    endfunction

    task automatic check_val(input string tag, input logic [LW-1:0] got,
                             input logic [LW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory model: one outstanding read, answered lat cycles after mem_rd.
    initial begin : responder
        logic [AW-1:0] a;
        forever begin
            @(negedge clk);
            if (mem_rd === 1'b1) begin
                a = mem_addr;
                repeat (lat) @(posedge clk);
                #1;
                resp_valid = 1'b1;
                resp_data  = mem_word(a);
                @(posedge clk);
                #1;
                resp_valid = 1'b0;
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (mem_rd === 1'b1) begin
                check_val("mem_rd_expected", LW'(exp_addr_q.size() != 0), LW'(1));
                if (exp_addr_q.size() != 0) begin
                    check_val("mem_addr", LW'(mem_addr), LW'(exp_addr_q.pop_front()));
                end
            end else begin
                check_val("mem_addr_idle_zero", LW'(mem_addr), '0);
            end
            if (fill_done === 1'b1) begin
                done_seen++;
                check_val("fill_done_expected", LW'(exp_line_q.size() != 0), LW'(1));
                if (exp_line_q.size() != 0) begin
                    check_val("line_data", line_data, exp_line_q.pop_front());
                end
            end
        end
    end

    function automatic logic [LW-1:0] push_fill(input logic [AW-1:0] addr);
        logic [AW-1:0] base;
        logic [LW-1:0] line;
        base = {addr[AW-1:2], 2'b00};
        line = '0;
        for (int i = 0; i < WC; i++) begin
            exp_addr_q.push_back(base + AW'(i));
            line[i*WS +: WS] = mem_word(base + AW'(i));
        end
        exp_line_q.push_back(line);
        return line;
    endfunction

    task automatic do_fill(input logic [AW-1:0] addr, input int unsigned l,
                           input int unsigned exp_n, input bit pulse_busy,
                           output logic [LW-1:0] line);
        int unsigned n;
        bit          busy_ok;
        line = push_fill(addr);
        lat  = l;
        @(negedge clk);
        fill_req  = 1'b1;
        fill_addr = addr;
        n = 0;
        busy_ok = 1'b1;
        while (n < 200) begin
            @(negedge clk);
            n++;
            fill_req = pulse_busy && (n == 3 || n == 5);
            if (fill_req) fill_addr = addr ^ 15'h0040;
            if (fill_busy !== 1'b1) busy_ok = 1'b0;
            if (fill_done === 1'b1) break;
        end
        fill_req = 1'b0;
        check_val("done_latency", LW'(n), LW'(exp_n));
        check_val("busy_held", LW'(busy_ok), LW'(1));
        if (exp_count < 16383) exp_count++;
        @(negedge clk);
        check_val("fill_count", LW'(fill_count), LW'(exp_count));
        check_val("busy_clear", LW'(fill_busy), '0);
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [LW-1:0] last_line;
        logic [LW-1:0] partial;
        int unsigned   saved_done;
        int unsigned   first_n;
        int unsigned   second_n;

        rst       = 1'b1;
        fill_req  = 1'b1;
        fill_addr = 15'h1236;
        sat_rst   = 1'b1;
        sat_inc   = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_busy", LW'(fill_busy), '0);
        check_val("rst_done", LW'(fill_done), '0);
        check_val("rst_mem_rd", LW'(mem_rd), '0);
        check_val("rst_line", line_data, '0);
        check_val("rst_count", LW'(fill_count), '0);
        rst      = 1'b0;
        fill_req = 1'b0;
        sat_rst  = 1'b0;
        @(negedge clk);
        check_val("post_rst_idle", LW'(fill_busy), '0);

        do_fill(15'h1236, 1, 9, 1'b0, last_line);

        // Stray rvalid while idle must not touch the line.
        inj_valid = 1'b1;
        inj_data  = 32'hDEAD_BEEF;
        @(negedge clk);
        inj_valid = 1'b0;
        @(negedge clk);
        check_val("stray_rvalid_line", line_data, last_line);
        check_val("stray_rvalid_busy", LW'(fill_busy), '0);

        do_fill(15'h0402, 3, 17, 1'b0, last_line);
        do_fill(15'h7FFF, 1, 9, 1'b0, last_line);
        do_fill(15'h0555, 1, 9, 1'b1, last_line);

        // Abort after word 1 lands, with word 2's read outstanding.
        partial = push_fill(15'h0101);
        void'(exp_line_q.pop_back());
        void'(exp_addr_q.pop_back());
        lat = 2;
        saved_done = done_seen;
        @(negedge clk);
        fill_req  = 1'b1;
        fill_addr = 15'h0101;
        for (int n = 1; n <= 7; n++) begin
            @(negedge clk);
            fill_req = 1'b0;
        end
        check_val("mid_fill_words01", LW'(line_data[2*WS-1:0]), LW'(partial[2*WS-1:0]));
        check_val("mid_fill_rd", LW'(mem_rd), LW'(1));
        rst = 1'b1;
        @(negedge clk);
        check_val("abort_busy", LW'(fill_busy), '0);
        check_val("abort_done", LW'(fill_done), '0);
        check_val("abort_rd", LW'(mem_rd), '0);
        check_val("abort_line", line_data, '0);
        check_val("abort_count", LW'(fill_count), '0);
        rst = 1'b0;
        exp_count = 0;
        repeat (6) @(negedge clk);
        check_val("late_rvalid_line", line_data, '0);
        check_val("late_rvalid_busy", LW'(fill_busy), '0);
        check_val("abort_no_done", LW'(done_seen), LW'(saved_done));
        check_val("abort_count_hold", LW'(fill_count), '0);

        // Back-to-back with fill_req held high through DONE.
        void'(push_fill(15'h2001));
        void'(push_fill(15'h2345));
        lat = 1;
        @(negedge clk);
        fill_req  = 1'b1;
        fill_addr = 15'h2001;
        first_n  = 0;
        second_n = 0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (n == 1) fill_addr = 15'h2345;
            if (n == 11) begin
                fill_req = 1'b0;
                check_val("b2b_second_req", LW'(mem_rd), LW'(1));
            end
            if (fill_done === 1'b1) begin
                if (first_n == 0) begin
                    first_n = n;
                end else begin
                    second_n = n;
                    break;
                end
            end
        end
        fill_req = 1'b0;
        check_val("b2b_first_done", LW'(first_n), LW'(9));
        check_val("b2b_second_done", LW'(second_n), LW'(19));
        exp_count += 2;
        @(negedge clk);
        check_val("b2b_count", LW'(fill_count), LW'(exp_count));

        repeat (4) @(negedge clk);
        check_val("addr_q_drained", LW'(exp_addr_q.size()), '0);
        check_val("line_q_drained", LW'(exp_line_q.size()), '0);

        // Saturation of the 14-bit counter.
        sat_inc = 1'b1;
        repeat (16382) @(negedge clk);
        check_val("sat_16382", LW'(sat_count), LW'(16382));
        @(negedge clk);
        check_val("sat_16383", LW'(sat_count), LW'(16383));
        repeat (8) @(negedge clk);
        check_val("sat_hold", LW'(sat_count), LW'(16383));
        sat_inc = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/line_fill_unit.md
LINE_FILL_UNIT -- requirements
Module: line_fill_unit

Interface
REQ-001 The block SHALL expose parameter WORD_SIZE, default 32, bits per memory word.
REQ-002 The block SHALL expose parameter WORD_COUNT, default 4, words per cache line (power of two).
REQ-003 The block SHALL expose parameter ADDR_WIDTH, default 15, word-address width.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset, with ports: clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 fill_req  in  1  line-fill request from cache on miss; sampled only in IDLE.
REQ-007 fill_addr  in  ADDR_WIDTH  word address of the missing word.
REQ-008 fill_busy  out  1  high while a fill is in progress (state != IDLE).
REQ-009 fill_done  out  1  one-cycle pulse; line_data holds the complete line.
REQ-010 line_data  out  WORD_COUNT*WORD_SIZE  assembled line; word i at bits [i*WORD_SIZE +: WORD_SIZE].
REQ-011 mem_rd  out  1  single-cycle word read strobe to main memory.
REQ-012 mem_addr  out  ADDR_WIDTH  word address for the current read.
REQ-013 mem_rdata  in  WORD_SIZE  read data from main memory.
REQ-014 mem_rvalid  in  1  mem_rdata valid this cycle; arrives 1 or more cycles after mem_rd.
REQ-015 fill_count  out  14  completed-fill (miss) count; saturates at 16383.

Function
REQ-016 The FSM SHALL have states IDLE, REQ, WAIT, DONE.
REQ-017 In IDLE with fill_req=1, the block SHALL latch base = {fill_addr[ADDR_WIDTH-1:log2(WORD_COUNT)], zeros}, clear word index, and go to REQ.
REQ-018 In REQ, the block SHALL drive mem_rd=1 and mem_addr=base+index for exactly one cycle, then go to WAIT.
REQ-019 In WAIT with mem_rvalid=1, the block SHALL write mem_rdata into line_data word [index]; if index==WORD_COUNT-1 go to DONE, else increment index and go to REQ.
REQ-020 In WAIT with mem_rvalid=0, the block SHALL hold state indefinitely (no timeout).
REQ-021 In DONE, the block SHALL assert fill_done for one cycle, increment fill_count (saturating), and return to IDLE.
REQ-022 Words SHALL be fetched in ascending order 0..WORD_COUNT-1 regardless of which word missed.
REQ-023 mem_rvalid outside WAIT SHALL be ignored; fill_req outside IDLE SHALL be ignored (not queued).
REQ-024 fill_req held high across DONE SHALL start a new fill on the IDLE cycle after DONE.
REQ-025 mem_addr SHALL be 0 whenever mem_rd=0.
REQ-026 line_data SHALL keep its value except for per-word writes in REQ-019; it is guaranteed complete only from the fill_done cycle until the first word of the next fill is captured.
REQ-027 With one-cycle memory latency, fill_done SHALL assert 9 cycles after the cycle fill_req is sampled (2 cycles/word plus DONE).

Reset
REQ-028 On rst=1 at a clock edge, state SHALL go to IDLE; fill_busy, fill_done, mem_rd, mem_addr, line_data, fill_count and the word index SHALL be 0.
REQ-029 rst SHALL abort an in-progress fill without asserting fill_done; a mem_rvalid arriving after reset SHALL be ignored.
REQ-030 rst SHALL take priority over fill_req in the same cycle.

Structure
REQ-031 WORD_SIZE, WORD_COUNT, ADDR_WIDTH defaults and the FSM state enumeration SHALL live in shared package cache_pkg.
REQ-032 The 14-bit saturating counter SHALL be one sub-module, sat_counter; everything else stays flat.

Verification
REQ-033 Single fill, 1-cycle memory: fill_addr=0x1236 -> mem_addr 0x1234,0x1235,0x1236,0x1237; fill_done at cycle 9; line_data = the four words in order; fill_count=1.
REQ-034 Variable latency: rvalid delayed 3 cycles per word -> no extra mem_rd, fill_done after 4 delayed responses, fill_busy high throughout.
REQ-035 Top-of-space wrap: fill_addr=0x7FFF -> reads 0x7FFC..0x7FFF, no address overflow.
REQ-036 Reset mid-fill after word 1 -> all outputs 0 next cycle, late rvalid ignored, no fill_done, fill_count unchanged.
REQ-037 Back-to-back: fill_req held high for two fills -> second REQ starts on the IDLE cycle after DONE; fill_req pulses during busy ignored.
REQ-038 Saturation: force 16384 fills -> fill_count stays 16383.
